// File: rtl/rv_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
package rv_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2
    } state_e;

    typedef enum logic {
        SrcFetch = 1'b0,
        SrcData  = 1'b1
    } grant_src_e;

endpackage

// File: rtl/rv_arb_timeout.sv
// Busy-cycle watchdog for rv_mem_arbiter; only instantiated when RVARB_TIMEOUT_EN is defined.
module rv_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    output logic expired_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || !run_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires during the TIMEOUT_CYCLES-th busy cycle.
    assign expired_o = run_i && (cnt_q == LastCnt);

endmodule

// File: rtl/rv_mem_arbiter.sv
// Fetch/data arbiter onto a single memory port with bounded data bursts.
// Define RVARB_TIMEOUT_EN to abort stuck accesses with bus_err.
module rv_mem_arbiter
    import rv_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_BURST = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wstrb,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_f,
    output logic        stall_m,
    output logic        bus_err
);
    localparam int unsigned BurstW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BurstW-1:0] MaxBurst = BurstW'(MAX_DATA_BURST);

    if (MAX_DATA_BURST == 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("rv_mem_arbiter: MAX_DATA_BURST must be >0 and TIMEOUT_CYCLES >=2");
    end

    state_e          state_q;
    logic [BurstW-1:0] burst_q;
    logic            first_q;
    logic            busy, served, timed_out, complete;
    logic            grant_d, grant_i;
    grant_src_e      src;

    assign busy   = (state_q != StIdle);
    // The first busy cycle only presents the request; memory answers from the next one on.
    assign served = busy && !first_q && mem_ready;

`ifdef RVARB_TIMEOUT_EN
    logic expired;

    rv_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk),
        .reset_i  (reset),
        .run_i    (busy),
        .expired_o(expired)
    );

    assign timed_out = expired && !served;
`else
    assign timed_out = 1'b0;
`endif

    assign complete = served || timed_out;
    assign if_ready = (state_q == StBusyI) && complete;
    assign dm_ready = (state_q == StBusyD) && complete;
    assign if_rdata = ((state_q == StBusyI) && served) ? mem_rdata : '0;
    assign dm_rdata = ((state_q == StBusyD) && served) ? mem_rdata : '0;
    assign bus_err  = timed_out;
    assign stall_f  = if_req & ~if_ready;
    assign stall_m  = dm_req & ~dm_ready;

    // Data wins unless a waiting fetch has already been starved for a full burst.
    assign grant_d = dm_req && (!if_req || (burst_q < MaxBurst));
    assign grant_i = !grant_d && if_req;
    assign src     = grant_d ? SrcData : SrcFetch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            burst_q   <= '0;
            first_q   <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            if (!if_req || (state_q == StIdle && grant_i)) begin
                burst_q <= '0;
            end else if (state_q == StIdle && grant_d && burst_q < MaxBurst) begin
                burst_q <= burst_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (grant_d || grant_i) begin
                        first_q   <= 1'b1;
                        mem_valid <= 1'b1;
                        if (src == SrcData) begin
                            state_q   <= StBusyD;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            mem_wstrb <= dm_wstrb;
                        end else begin
                            state_q   <= StBusyI;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                StBusyI, StBusyD: begin
                    first_q <= 1'b0;
                    if (complete) begin
                        state_q   <= StIdle;
                        mem_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed scoreboard bench for rv_mem_arbiter (honours RVARB_TIMEOUT_EN if defined).
module tb_rv_mem_arbiter;

    localparam int unsigned TO = 8;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_valid, mem_we, stall_f, stall_m, bus_err;
    logic [3:0]  mem_wstrb;

    int   checks = 0;
    int   errors = 0;
    txn_t sb_q[$];

    rv_mem_arbiter #(
        .MAX_DATA_BURST(4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_wstrb (dm_wstrb),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .stall_f  (stall_f),
        .stall_m  (stall_m),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic d, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
        txn_t t;
        t.is_data = d;
        t.we      = we;
        t.addr    = a;
        t.wdata   = wd;
        t.wstrb   = ws;
        sb_q.push_back(t);
    endtask

    task automatic pop_cmp(input string tag, output txn_t cur);
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            chk({tag, "_addr"}, mem_addr, cur.addr);
            chk({tag, "_we"}, 32'(mem_we), 32'(cur.we));
            chk({tag, "_wdata"}, mem_wdata, cur.wdata);
            chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(cur.wstrb));
        end else begin
            cur = '{default: '0};
        end
    endtask

    // Follow one transaction from grant to ready; request is already driven.
    task automatic serve(input string tag, input logic [31:0] rd);
        bit   seen = 0;
        bit   done = 0;
        txn_t cur  = '{default: '0};
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_valid && !seen) begin
                seen = 1;
                pop_cmp(tag, cur);
            end
            if (if_ready || dm_ready) begin
                done = 1;
                chk({tag, "_src"}, 32'(dm_ready), 32'(cur.is_data));
                chk({tag, "_rdata"}, cur.is_data ? dm_rdata : if_rdata, rd);
                chk({tag, "_other_rdata"}, cur.is_data ? if_rdata : dm_rdata, 32'd0);
            end
        end
        chk({tag, "_completed"}, 32'(done), 32'd1);
    endtask

    initial begin
        txn_t cur;
        int   n;
        int   last;
        bit   mv_prev;

        reset = 1'b1;
        if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0; mem_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_readies", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);

        // Single fetch: valid in cycle 1, ready with data in cycle 2
        tick();
        if_req = 1; if_addr = 32'h100; mem_rdata = 32'h13;
        push(0, 0, 32'h100, 32'h0, 4'h0);
        @(negedge clk);
        chk("A_c0_valid", 32'(mem_valid), 32'd0);
        chk("A_c0_stall_f", 32'(stall_f), 32'd1);
        tick();
        mem_ready = 1;
        @(negedge clk);
        chk("A_c1_valid", 32'(mem_valid), 32'd1);
        pop_cmp("A", cur);
        chk("A_c1_ready", 32'(if_ready), 32'd0);
        chk("A_c1_rdata", if_rdata, 32'd0);
        tick();
        @(negedge clk);
        chk("A_c2_ready", 32'(if_ready), 32'd1);
        chk("A_c2_rdata", if_rdata, 32'h13);
        chk("A_c2_stall_f", 32'(stall_f), 32'd0);
        tick();
        if_req = 0; mem_ready = 0;
        @(negedge clk);
        chk("A_c3_valid", 32'(mem_valid), 32'd0);
        chk("A_c3_ready", 32'(if_ready), 32'd0);

        // Simultaneous requests: data first, then fetch
        tick();
        if_req = 1; if_addr = 32'h200;
        dm_req = 1; dm_we = 0; dm_addr = 32'h300; dm_wdata = 32'h0; dm_wstrb = 4'hf;
        mem_ready = 1; mem_rdata = 32'haaaa_0001;
        push(1, 0, 32'h300, 32'h0, 4'hf);
        push(0, 0, 32'h200, 32'h0, 4'h0);
        serve("B_data", 32'haaaa_0001);
        tick();
        dm_req = 0;
        serve("B_fetch", 32'haaaa_0001);
        tick();
        if_req = 0; mem_ready = 0;

        // Continuous data with a pending fetch: four data grants, then the fetch
        tick();
        if_req = 1; if_addr = 32'h1000;
        dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hdead_beef; dm_wstrb = 4'hf;
        mem_ready = 1; mem_rdata = 32'h0000_c0de;
        for (int k = 0; k < 4; k++) push(1, 1, 32'h2000, 32'hdead_beef, 4'hf);
        push(0, 0, 32'h1000, 32'h0, 4'h0);
        n = 0; last = 0; mv_prev = 0;
        cur = '{default: '0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_valid && !mv_prev) pop_cmp("C", cur);
            mv_prev = mem_valid;
            if (if_ready || dm_ready) begin
                chk("C_src", 32'(dm_ready), 32'(cur.is_data));
                chk("C_rdata", dm_ready ? dm_rdata : if_rdata, 32'h0000_c0de);
                if (n > 0) chk("C_gap", 32'(i - last), 32'd3);
                last = i;
                n++;
                if (n == 5) break;
            end
        end
        chk("C_count", 32'(n), 32'd5);
        tick();
        if_req = 0; dm_req = 0; mem_ready = 0;

        // Write held off by memory for 5 cycles: request stays stable
        tick();
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'h1234_5678; dm_wstrb = 4'h3;
        mem_rdata = 32'h55;
        push(1, 1, 32'h40, 32'h1234_5678, 4'h3);
        @(negedge clk);
        chk("D_c0_stall_m", 32'(stall_m), 32'd1);
        tick();
        @(negedge clk);
        pop_cmp("D", cur);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin
                tick();
                @(negedge clk);
            end
            chk("D_valid", 32'(mem_valid), 32'd1);
            chk("D_addr", mem_addr, 32'h40);
            chk("D_wdata", mem_wdata, 32'h1234_5678);
            chk("D_wstrb", 32'(mem_wstrb), 32'h3);
            chk("D_stall_m", 32'(stall_m), 32'd1);
            chk("D_no_ready", 32'(dm_ready), 32'd0);
        end
        tick();
        mem_ready = 1;
        @(negedge clk);
        chk("D_ready", 32'(dm_ready), 32'd1);
        chk("D_stall_m_done", 32'(stall_m), 32'd0);
        chk("D_rdata", dm_rdata, 32'h55);
        tick();
        dm_req = 0;
        @(negedge clk);
        chk("D_idle_valid", 32'(mem_valid), 32'd0);

        // mem_ready while idle is ignored
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            chk("E_idle_valid", 32'(mem_valid), 32'd0);
            chk("E_idle_readies", {30'd0, if_ready, dm_ready}, 32'd0);
        end

        // Memory never answers a fetch
        tick();
        mem_ready = 0; if_req = 1; if_addr = 32'h500; mem_rdata = 32'hffff_ffff;
        push(0, 0, 32'h500, 32'h0, 4'h0);
        @(negedge clk);
`ifdef RVARB_TIMEOUT_EN
        for (int c = 1; c <= int'(TO); c++) begin
            tick();
            @(negedge clk);
            if (c == 1) pop_cmp("F", cur);
            if (c < int'(TO)) begin
                chk("F_wait_ready", 32'(if_ready), 32'd0);
            end else begin
                chk("F_to_ready", 32'(if_ready), 32'd1);
                chk("F_to_bus_err", 32'(bus_err), 32'd1);
                chk("F_to_rdata", if_rdata, 32'd0);
            end
        end
        tick();
        if_req = 0;
        @(negedge clk);
        chk("F_to_valid", 32'(mem_valid), 32'd0);
`else
        for (int c = 1; c <= 20; c++) begin
            tick();
            @(negedge clk);
            if (c == 1) pop_cmp("F", cur);
            chk("F_stall_f", 32'(stall_f), 32'd1);
            chk("F_no_ready", 32'(if_ready), 32'd0);
            chk("F_bus_err", 32'(bus_err), 32'd0);
        end
`endif
        tick();
        reset = 1; if_req = 0;
        tick();
        reset = 0;
        @(negedge clk);
        chk("F_rst_valid", 32'(mem_valid), 32'd0);

        // Reset in the middle of a data access
        tick();
        dm_req = 1; dm_we = 0; dm_addr = 32'h80; dm_wstrb = 4'hf; dm_wdata = 32'h0;
        push(1, 0, 32'h80, 32'h0, 4'hf);
        tick();
        @(negedge clk);
        pop_cmp("G", cur);
        tick();
        reset = 1;
        @(negedge clk);
        chk("G_busy_no_ready", 32'(dm_ready), 32'd0);
        tick();
        mem_ready = 1;
        @(negedge clk);
        chk("G_rst_valid", 32'(mem_valid), 32'd0);
        chk("G_rst_addr", mem_addr, 32'd0);
        chk("G_rst_ready", 32'(dm_ready), 32'd0);
        tick();
        reset = 0; dm_req = 0;
        @(negedge clk);
        chk("G_post_ready", 32'(dm_ready), 32'd0);
        chk("G_post_valid", 32'(mem_valid), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
